counter_sequencer: RTL

Control block that sequences the 4-bit display counter datapath: generates the counting tick from the board clock, and starts, pauses, clears, loads and sets the direction of the count. Sits between the debounced push-button/switch inputs and the LED counter output. It replaces a divided clock with a single-cycle enable, so the whole block runs in the `clk` domain.

---
 rtl/cnt_pkg.sv | 17 +
 rtl/tick_gen.sv | 37 +++
 rtl/counter_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared types and defaults for the counter sequencer
// Contents:
//   state_t        sequencer state encoding (IDLE, RUN, PAUSED)
//   DEFAULT_WIDTH  default counter width in bits
//   DEFAULT_DIV    default clk cycles per count tick (100 MHz -> 10 Hz)
package cnt_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      PAUSED = 2'b10
   } state_t;

   localparam int DEFAULT_WIDTH = 4;
   localparam int DEFAULT_DIV   = 10_000_000;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing the end-of-period flag for the count tick
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset, clears the prescaler
//   en    in  advance the prescaler this cycle (wraps DIV-1 -> 0)
//   sclr  in  synchronous clear of the prescaler, dominates en
//   tick  out high while the prescaler sits at DIV-1
module tick_gen
   import cnt_pkg::*;
#(
   parameter int DIV = DEFAULT_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sclr,
   output logic tick
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] pre;

   always_ff @(posedge clk) begin
      if (rst || sclr) begin
         pre <= '0;
      end else if (en) begin
         pre <= (pre == LAST) ? '0 : pre + PW'(1);
      end
   end

   // Not gated by en: the caller qualifies it with its own run state, so a
   // held prescaler does not suppress the flag in the cycle it is sampled.
   assign tick = (pre == LAST);

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - start/pause/clear/load sequencing of the display counter
// Ports:
//   clk       in  system clock, single domain
//   rst       in  synchronous active-high reset
//   start     in  IDLE or PAUSED -> RUN
//   pause     in  RUN -> PAUSED
//   clear     in  count and prescaler to 0, state to IDLE
//   load      in  count <= load_val, prescaler to 0, state unchanged
//   load_val  in  value for load
//   up_dn     in  count direction sampled on each tick (1 = up)
//   count     out current count (registered)
//   running   out high while in RUN (registered)
//   tick      out one-cycle count enable (combinational)
//   wrap      out one-cycle registered pulse after a 15->0 or 0->15 step
module counter_sequencer
   import cnt_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DIV   = DEFAULT_DIV
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pause,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             up_dn,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             tick,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] count_next;
   logic             wrap_next;
   logic             pre_en;
   logic             pre_sclr;
   logic             period_end;

   tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (pre_en),
      .sclr (pre_sclr),
      .tick (period_end)
   );

   assign tick = (state == RUN) && period_end;

   // A pause freezes the prescaler in the same cycle so that the resume
   // finishes exactly the interrupted period.
   assign pre_en = (state == RUN) && !pause;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         wrap    <= 1'b0;
         running <= 1'b0;
      end else begin
         state   <= state_next;
         count   <= count_next;
         wrap    <= wrap_next;
         running <= (state_next == RUN);
      end
   end

   always_comb begin
      state_next = state;
      count_next = count;
      wrap_next  = 1'b0;
      pre_sclr   = 1'b0;

      if (clear) begin
         count_next = '0;
         state_next = IDLE;
         pre_sclr   = 1'b1;
      end else if (load) begin
         // load also wins over start, so the state is left as it was
         count_next = load_val;
         pre_sclr   = 1'b1;
      end else if (pause && (state == RUN)) begin
         state_next = PAUSED;
         // a tick dropped by the pause restarts the period from 0
         pre_sclr   = tick;
      end else begin
         if (start && (state != RUN)) begin
            state_next = RUN;
         end
         if (tick) begin
            if (up_dn) begin
               count_next = count + WIDTH'(1);
               wrap_next  = (count == CNT_MAX);
            end else begin
               count_next = count - WIDTH'(1);
               wrap_next  = (count == '0);
            end
         end
      end

      // unused encoding recovers to IDLE
      if ((state != IDLE) && (state != RUN) && (state != PAUSED)) begin
         state_next = IDLE;
      end
   end

endmodule
